// File: rtl/hilo_divide_unit.sv
// Iterative radix-2 restoring divider that owns the MIPS HI/LO register pair.
// Each CALC cycle produces one quotient bit. The final FIX cycle applies the signs and writes HI/LO.
module hilo_divide_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Signed,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  ReadHi,
  input  logic                  ReadLo,
  input  logic                  WriteHi,
  input  logic                  WriteLo,
  input  logic [DATA_WIDTH-1:0] WData,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic                  Stall
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                state;
  state_t                stateNext;
  logic [CNT_W-1:0]      counter;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  signQ;
  logic                  signR;
  logic [DATA_WIDTH:0]   remShift;
  logic [DATA_WIDTH-1:0] remSub;
  logic                  remGe;

  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] v,
                                                      input logic isSigned);
    logic signed [DATA_WIDTH-1:0] neg;
    neg = -v;
    return (isSigned && v < 0) ? neg : v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] applySign(input logic [DATA_WIDTH-1:0] v,
                                                      input logic negate);
    return negate ? -v : v;
  endfunction

  // The shifted partial remainder needs one extra bit. The difference always fits in DATA_WIDTH bits.
  always_comb begin
    remShift = {rem, quo[DATA_WIDTH-1]};
    remGe    = (remShift >= {1'b0, divisor});
    remSub   = remShift[DATA_WIDTH-1:0] - divisor;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Start) stateNext = CALC;
      CALC:    if (counter == CNT_W'(1)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  assign Busy  = (state != IDLE);
  assign Stall = Busy & (ReadHi | ReadLo | WriteHi | WriteLo | Start);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      counter   <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      signQ     <= 1'b0;
      signR     <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          // An accepted divide takes priority over a simultaneous mthi/mtlo.
          if (Start) begin
            quo       <= magnitude(A, Signed);
            divisor   <= magnitude(B, Signed);
            rem       <= '0;
            signQ     <= Signed & (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
            signR     <= Signed & A[DATA_WIDTH-1];
            DivByZero <= (B == '0);
            counter   <= CNT_W'(DATA_WIDTH);
          end else begin
            if (WriteHi) HI <= WData;
            if (WriteLo) LO <= WData;
          end
        end
        CALC: begin
          rem     <= remGe ? remSub : remShift[DATA_WIDTH-1:0];
          quo     <= {quo[DATA_WIDTH-2:0], remGe};
          counter <= counter - CNT_W'(1);
        end
        FIX: begin
          // With a zero divisor the remainder equals |A|, so re-signing it restores A.
          LO   <= DivByZero ? '1 : applySign(quo, signQ);
          HI   <= applySign(rem, signR);
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_divide_unit.sv
// Directed and randomized bench for hilo_divide_unit.
// Expected results come from a 64-bit arithmetic reference model.
module tb_hilo_divide_unit;
  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset, Start, Signed, ReadHi, ReadLo, WriteHi, WriteLo;
  logic [W-1:0] A, B, WData, HI, LO;
  logic         Busy, Done, DivByZero, Stall;
  int           checkCount = 0;
  int           failCount  = 0;

  hilo_divide_unit #(.DATA_WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed), .A(A), .B(B),
    .ReadHi(ReadHi), .ReadLo(ReadLo), .WriteHi(WriteHi), .WriteLo(WriteLo), .WData(WData),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Stall(Stall)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: truncating division on 64-bit values; zero divisor gives HI=A, LO=all ones.
  function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb, q, r;
    if (b == '0) begin
      hi = a;
      lo = '1;
    end else begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    A = a; B = b; Signed = sgn; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic waitDone(input int already, input string tag);
    int n;
    n = already;
    while (!Done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "-latency"}, n, 33);
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sgn);
    logic [W-1:0] eHi, eLo;
    refDiv(a, b, sgn, eHi, eLo);
    check({tag, "-HI"}, HI, eHi);
    check({tag, "-LO"}, LO, eLo);
    check1({tag, "-dbz"}, DivByZero, (b == '0));
    check1({tag, "-busy"}, Busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, hiBefore;
    logic         rs;
    int           sel, n;

    Reset = 1'b1; Start = 0; Signed = 0; A = '0; B = '0;
    ReadHi = 0; ReadLo = 0; WriteHi = 0; WriteLo = 0; WData = '0;
    #1;
    check1("rst-busy", Busy, 1'b0);
    check1("rst-done", Done, 1'b0);
    check1("rst-dbz", DivByZero, 1'b0);
    check1("rst-stall", Stall, 1'b0);
    check("rst-HI", HI, '0);
    check("rst-LO", LO, '0);
    tick(); tick();
    Reset = 1'b0;

    // divu 11/3 with a concurrent mthi that must lose to the divide
    WriteHi = 1'b1; WData = 32'hDEADBEEF;
    issue(32'd11, 32'd3, 1'b0);
    WriteHi = 1'b0;
    check("t1-HI-kept", HI, '0);
    check1("t1-busy", Busy, 1'b1);
    waitDone(0, "t1");
    checkResult("t1", 32'd11, 32'd3, 1'b0);
    check("t1-LO-const", LO, 32'd3);
    check("t1-HI-const", HI, 32'd2);
    tick();
    check1("t1-done-pulse", Done, 1'b0);

    // signed: -7/2 and the overflow case
    issue(32'hFFFFFFF9, 32'd2, 1'b1);
    waitDone(0, "t2a");
    checkResult("t2a", 32'hFFFFFFF9, 32'd2, 1'b1);
    check("t2a-LO-const", LO, 32'hFFFFFFFD);
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
    waitDone(0, "t2b");
    checkResult("t2b", 32'h80000000, 32'hFFFFFFFF, 1'b1);
    check("t2b-LO-const", LO, 32'h80000000);

    // divide by zero, signed case too, then a clean divide clears the flag
    issue(32'd5, 32'd0, 1'b0);
    check1("t3-dbz-early", DivByZero, 1'b1);
    waitDone(0, "t3a");
    checkResult("t3a", 32'd5, 32'd0, 1'b0);
    issue(32'hFFFFFFF0, 32'd0, 1'b1);
    waitDone(0, "t3b");
    checkResult("t3b", 32'hFFFFFFF0, 32'd0, 1'b1);
    issue(32'd6, 32'd3, 1'b0);
    waitDone(0, "t3c");
    checkResult("t3c", 32'd6, 32'd3, 1'b0);

    // back-to-back randomized divides, each issued in the Done cycle of the previous one
    for (int i = 0; i < 10; i++) begin
      check1("rnd-done-coincide", Done, 1'b1);
      ra  = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0)      rb = '0;
      else if (sel == 1) rb = W'($urandom_range(1, 15));
      else if (sel == 2) rb = -W'($urandom_range(1, 15));
      else               rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs);
      check1("rnd-busy", Busy, 1'b1);
      waitDone(0, "rnd");
      checkResult("rnd", ra, rb, rs);
    end
    tick();

    // mthi in IDLE
    WriteHi = 1'b1; WData = 32'hCAFEF00D;
    tick();
    WriteHi = 1'b0;
    check("mthi", HI, 32'hCAFEF00D);

    // hazard: mfhi held and mtlo attempted throughout the divide
    issue(32'd1000, 32'd10, 1'b0);
    ReadHi = 1'b1; WriteLo = 1'b1; WData = 32'h1234;
    n = 0;
    while (!Done && n < 40) begin
      check1("t4-stall", Stall, 1'b1);
      tick();
      n++;
    end
    check("t4-latency", n, 33);
    check1("t4-stall-release", Stall, 1'b0);
    check("t4-LO", LO, 32'd100);
    check("t4-HI", HI, 32'd0);
    tick();
    check("t4-mtlo", LO, 32'h1234);
    ReadHi = 1'b0; WriteLo = 1'b0;

    // a second Start during Busy is ignored
    issue(32'd77, 32'd5, 1'b0);
    repeat (4) tick();
    A = 32'd9; B = 32'd2; Start = 1'b1;
    #1;
    check1("t5-stall", Stall, 1'b1);
    tick();
    Start = 1'b0;
    waitDone(5, "t5");
    checkResult("t5", 32'd77, 32'd5, 1'b0);

    // asynchronous reset in the middle of a divide
    issue(32'h55, 32'd0, 1'b0);
    repeat (10) tick();
    hiBefore = HI;
    check("t6-HI-pre", hiBefore, 32'd2);
    check1("t6-dbz-pre", DivByZero, 1'b1);
    #2 Reset = 1'b1;
    #1;
    check1("t6-busy", Busy, 1'b0);
    check1("t6-dbz", DivByZero, 1'b0);
    check1("t6-done", Done, 1'b0);
    check("t6-HI", HI, '0);
    check("t6-LO", LO, '0);
    tick();
    Reset = 1'b0;
    issue(32'd100, 32'd7, 1'b0);
    waitDone(0, "t6b");
    checkResult("t6b", 32'd100, 32'd7, 1'b0);
    check("t6b-LO-const", LO, 32'd14);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end
endmodule

// File: doc/hilo_divide_unit.md
Name: hilo_divide_unit

Overview:
- Iterative multi-cycle divide unit that owns the HI/LO register pair for the mips32 pipeline.
- The EX stage issues div/divu here. Mfhi/mflo, mthi and mtlo requests from EX read or write HI/LO.
- The unit raises Stall back to the hazard logic until a pending result is written.
- One radix-2 restoring step per cycle, plus one sign-fix/writeback cycle.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH

Ports:
Clock      input   1           rising-edge clock
Reset      input   1           asynchronous, active-high; clears all state
Start      input   1           issue divide; sampled only in IDLE
Signed     input   1           1 = div (two's complement), 0 = divu; sampled with Start
A          input   DATA_WIDTH  dividend (EX rs, post-forwarding)
B          input   DATA_WIDTH  divisor (EX rt, post-forwarding)
ReadHi     input   1           EX executing mfhi
ReadLo     input   1           EX executing mflo
WriteHi    input   1           mthi write strobe
WriteLo    input   1           mtlo write strobe
WData      input   DATA_WIDTH  mthi/mtlo data
HI         output  DATA_WIDTH  remainder register
LO         output  DATA_WIDTH  quotient register
Busy       output  1           division in progress
Done       output  1           one-cycle pulse after HI/LO are written by a divide
DivByZero  output  1           sticky flag: last divide had B==0; cleared on next accepted Start
Stall      output  1           combinational: Busy & (ReadHi|ReadLo|WriteHi|WriteLo|Start)

Behaviour:
- Reset (asynchronous): state=IDLE, HI=LO=0, Busy=0, Done=0, DivByZero=0, counter=0.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - Start=1 at edge E0 captures the operands.
  - divu uses |A| = A and |B| = B. div converts to magnitudes and latches signQ = A[msb]^B[msb] and signR = A[msb].
  - Also at E0: DivByZero <= (B==0), Busy <= 1, counter <= DATA_WIDTH, go to CALC.
- CALC:
  - Each edge: shift {rem,quo} left 1. If rem >= |B|, subtract and set quo LSB.
  - counter decrements; at counter==1 go to FIX. CALC occupies edges E1..E32 for DATA_WIDTH=32.
- FIX, edge E33:
  - LO <= signQ ? -quo : quo. HI <= signR ? -rem : rem.
  - Busy <= 0, Done <= 1 for exactly the following cycle. Go to IDLE.
  - Latency: result visible on HI/LO DATA_WIDTH+1 edges after the Start edge.
- Divide by zero:
  - Full latency still applies. Result is HI = A (original dividend), LO = all ones (both signed and unsigned).
  - DivByZero = 1.
- Signed overflow (A = 0x80000000, B = 0xFFFFFFFF): LO = 0x80000000, HI = 0. No flag.
- Signed rounding: quotient truncates toward zero; the remainder carries the sign of the dividend.
- Start while Busy: ignored (no restart, no operand capture). Stall=1 holds the issuing instruction in EX.
- mthi/mtlo:
  - WriteHi/WriteLo in IDLE update HI/LO at the next edge.
  - While Busy they are ignored and Stall=1.
  - WriteHi together with Start in IDLE: the divide wins and the write is discarded.
- ReadHi/ReadLo: HI/LO are always driven from registers. A read during Busy gets Stall=1 until the cycle in which Busy=0.
- Done and a new Start may coincide in the same cycle: Start is accepted normally.
- Reset mid-CALC: immediate return to IDLE with all outputs at reset values. The partial result is discarded.
- HI/LO are stable except at FIX, mthi/mtlo write, or Reset.

Test Plan:
1. divu: A=11, B=3, Start one cycle -> Busy=1 for 33 cycles. LO=3, HI=2 after E33; Done pulse 1 cycle; DivByZero=0.
2. div: A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Separately, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
3. divu: A=5, B=0 -> HI=5, LO=0xFFFFFFFF, DivByZero=1. The next divu 6/3 clears the flag -> LO=2, HI=0.
4. Hazard:
   - Hold ReadHi=1 from E1 onward -> Stall=1 through the FIX cycle, Stall=0 once Busy=0.
   - A WriteLo of 0x1234 during Busy is ignored. After Done, WriteLo of 0x1234 -> LO=0x1234 next edge.
5. Start again at E5 with different operands -> ignored; the first result completes unchanged.
6. Assert Reset asynchronously mid-cycle at E10 of a divide -> Busy, HI, LO and DivByZero go to 0 immediately, without a clock edge. After Reset is released, a divu 100/7 -> LO=14, HI=2.
